// File: rtl/gemm_tile_sequencer_pkg.sv
// gemm_tile_sequencer_pkg: shared types and sizing helpers for the GEMM tile sequencer.
// Contents: the state_e enum, drain_cyc() for the drain length, and row_w() for the result-row index width.
package gemm_seq_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, WRITE, DONE} state_e;

    // Cycles for the last operand to leave the buffer pipe, cross the skew and reach the far PE.
    function automatic int drain_cyc(input int dim, input int rd_lat);
        return rd_lat + 2 * (dim - 1) + 1;
    endfunction

    function automatic int row_w(input int dim);
        return (dim > 1) ? $clog2(dim) : 1;
    endfunction

endpackage

// File: rtl/gemm_tile_sequencer_if.sv
// gemm_tile_sequencer_if: command, operand-read, PE-control and result-write signals of the sequencer.
// Signals:
//   start, k_len   command strobe and K length from the host
//   busy, done     status back to the host
//   a_rd_en, b_rd_en, rd_addr   operand buffer reads
//   pe_clear, skew_valid        PE array control
//   c_wr_en, c_wr_row, c_wr_ready   result row write handshake
// Modports: master = sequencer side, slave = host/datapath side.
interface gemm_tile_sequencer_if
    import gemm_seq_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int K_W    = 16,
    parameter int ADDR_W = 10
);
    localparam int RW = row_w(DIM);

    logic              start;
    logic [K_W-1:0]    k_len;
    logic              busy;
    logic              done;
    logic              a_rd_en;
    logic              b_rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pe_clear;
    logic [DIM-1:0]    skew_valid;
    logic              c_wr_en;
    logic [RW-1:0]     c_wr_row;
    logic              c_wr_ready;

    modport master (
        input  start, k_len, c_wr_ready,
        output busy, done, a_rd_en, b_rd_en, rd_addr, pe_clear, skew_valid, c_wr_en, c_wr_row
    );

    modport slave (
        output start, k_len, c_wr_ready,
        input  busy, done, a_rd_en, b_rd_en, rd_addr, pe_clear, skew_valid, c_wr_en, c_wr_row
    );

endinterface

// File: rtl/gemm_tile_sequencer_skew.sv
// skew_valid_line: 1-bit delay chain of depth RD_LAT+DIM-1 that turns the feed strobe into per-row skewed valids.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_flush     synchronous clear of every stage
//   i_valid     undelayed feed strobe
//   o_skew      o_skew[i] = i_valid delayed RD_LAT+i cycles
module skew_valid_line #(
    parameter int DIM    = 4,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_flush,
    input  logic           i_valid,
    output logic [DIM-1:0] o_skew
);
    localparam int DEPTH = RD_LAT + DIM - 1;

    logic [DEPTH-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_chain <= '0;
        else if (i_flush)
            r_chain <= '0;
        else
            r_chain <= {r_chain[DEPTH-2:0], i_valid};
    end

    // Stage n holds the input delayed n+1 cycles, so row 0 taps stage RD_LAT-1.
    assign o_skew = r_chain[DEPTH-1:RD_LAT-1];

endmodule

// File: rtl/gemm_tile_sequencer.sv
// gemm_tile_sequencer: control FSM running one DIM x DIM output tile (clear, feed K slices, drain, write back rows).
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   bus         gemm_tile_sequencer_if.master (command, operand reads, PE control, result writes)
//   i_abort, o_aborted   only with GEMM_SEQ_ABORT_EN: abort any running tile back to IDLE and flag it for one cycle
// All outputs are Moore, decoded from the registered state and counters.
module gemm_tile_sequencer
    import gemm_seq_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int K_W    = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    gemm_tile_sequencer_if.master bus
`ifdef GEMM_SEQ_ABORT_EN
    ,
    input  logic i_abort,
    output logic o_aborted
`endif
);
    localparam int DC = drain_cyc(DIM, RD_LAT);
    localparam int RW = row_w(DIM);
    localparam int DW = $clog2(DC + 1);
    // One counter serves both the feed slices and the drain cycles.
    localparam int CW = (K_W > DW) ? K_W : DW;

    state_e         r_state, w_state;
    logic [CW-1:0]  r_cnt, w_cnt;
    logic [RW-1:0]  r_row, w_row;
    logic [K_W-1:0] r_k, w_k;
    logic           w_flush;

`ifdef GEMM_SEQ_ABORT_EN
    assign w_flush = i_abort && (r_state != IDLE);

    logic r_aborted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_aborted <= 1'b0;
        else
            r_aborted <= w_flush;
    end

    assign o_aborted = r_aborted;
`else
    assign w_flush = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_row   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_row   <= w_row;
            r_k     <= w_k;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_row   = r_row;
        w_k     = r_k;
        case (r_state)
            IDLE: if (bus.start) begin
                w_state = CLEAR;
                w_k     = bus.k_len;
                w_cnt   = '0;
                w_row   = '0;
            end
            CLEAR: w_state = (r_k == '0) ? DRAIN : FEED;
            FEED: if (r_cnt == CW'(r_k) - CW'(1)) begin
                w_state = DRAIN;
                w_cnt   = '0;
            end else
                w_cnt = r_cnt + CW'(1);
            DRAIN: if (r_cnt == CW'(DC - 1)) begin
                w_state = WRITE;
                w_cnt   = '0;
            end else
                w_cnt = r_cnt + CW'(1);
            WRITE: if (bus.c_wr_ready) begin
                if (r_row == RW'(DIM - 1))
                    w_state = DONE;
                else
                    w_row = r_row + RW'(1);
            end
            default: w_state = IDLE;
        endcase
        if (w_flush) begin
            w_state = IDLE;
            w_cnt   = '0;
            w_row   = '0;
        end
    end

    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);
    assign bus.pe_clear = (r_state == CLEAR);
    assign bus.a_rd_en  = (r_state == FEED);
    assign bus.b_rd_en  = (r_state == FEED);
    assign bus.rd_addr  = (r_state == FEED) ? ADDR_W'(r_cnt) : '0;
    assign bus.c_wr_en  = (r_state == WRITE);
    assign bus.c_wr_row = (r_state == WRITE) ? r_row : '0;

    skew_valid_line #(.DIM(DIM), .RD_LAT(RD_LAT)) u_skew (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_valid (r_state == FEED),
        .o_skew  (bus.skew_valid)
    );

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// tb_gemm_tile_sequencer: randomized scoreboard bench for gemm_tile_sequencer.
module tb_gemm_tile_sequencer;
    localparam int DIM    = 4;
    localparam int K_W    = 16;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 1;
    localparam int DC     = RD_LAT + 2 * (DIM - 1) + 1;

    typedef struct {int cyc; int val;} ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    gemm_tile_sequencer_if #(.DIM(DIM), .K_W(K_W), .ADDR_W(ADDR_W)) bus ();

`ifdef GEMM_SEQ_ABORT_EN
    logic abort;
    logic aborted;
`endif

    gemm_tile_sequencer #(.DIM(DIM), .K_W(K_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef GEMM_SEQ_ABORT_EN
        ,
        .i_abort   (abort),
        .o_aborted (aborted)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events, pushed by the stimulus, popped by the monitor.
    int  clr_q[$];
    int  done_q[$];
    ev_t rd_q[$];
    ev_t wr_q[$];
    bit  nrdy[int];
    int  stall[DIM];
    int  busy_lo = 0, busy_hi = -1;
    int  wr_lo = 0, wr_hi = -1;
    int  feed_start = 0, feed_k = 0;
    ev_t mon_e;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.c_wr_ready = !nrdy.exists(cyc);
    end

    // Monitor: compares every cycle against the model's windows and queues.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", bus.busy, (cyc >= busy_lo && cyc <= busy_hi));
            chk("rd_en_pair", bus.a_rd_en, bus.b_rd_en);
            chk("c_wr_en", bus.c_wr_en, (cyc >= wr_lo && cyc <= wr_hi));
            for (int i = 0; i < DIM; i++)
                chk($sformatf("skew_valid[%0d]", i), bus.skew_valid[i],
                    (feed_k > 0 && cyc - RD_LAT - i >= feed_start && cyc - RD_LAT - i < feed_start + feed_k));
            if (bus.pe_clear) begin
                if (clr_q.size() == 0) chk("pe_clear_unexpected", 1, 0);
                else chk("pe_clear_cycle", cyc, clr_q.pop_front());
            end
            if (bus.a_rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    mon_e = rd_q.pop_front();
                    chk("rd_cycle", cyc, mon_e.cyc);
                    chk("rd_addr", bus.rd_addr, mon_e.val);
                end
            end
            if (bus.c_wr_en) begin
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else if (bus.c_wr_ready) begin
                    mon_e = wr_q.pop_front();
                    chk("wr_accept_cycle", cyc, mon_e.cyc);
                    chk("wr_row", bus.c_wr_row, mon_e.val);
                end else
                    chk("wr_row_hold", bus.c_wr_row, wr_q[0].val);
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, done_q.pop_front());
            end
        end
    end

    // Issue one accepted command and push everything the model predicts for it.
    task automatic issue(input int k, output int t0, output int dn);
        int acc;
        @(posedge clk); #1;
        t0 = cyc;
        bus.start = 1'b1;
        bus.k_len = K_W'(k);
        clr_q.push_back(t0 + 1);
        for (int j = 0; j < k; j++) rd_q.push_back('{t0 + 2 + j, j % (1 << ADDR_W)});
        feed_start = t0 + 2;
        feed_k     = k;
        acc        = t0 + 2 + k + DC;
        wr_lo      = acc;
        for (int r = 0; r < DIM; r++) begin
            for (int s = 0; s < stall[r]; s++) nrdy[acc + s] = 1'b1;
            acc += stall[r];
            wr_q.push_back('{acc, r});
            acc++;
        end
        dn      = acc;
        wr_hi   = dn - 1;
        busy_lo = t0 + 1;
        busy_hi = dn;
        done_q.push_back(dn);
    endtask

    // Run to the done cycle; with noise, start toggles while busy and is held high at done.
    task automatic finish(input int dn, input bit noise);
        while (cyc < dn) begin
            @(posedge clk); #1;
            bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.k_len = K_W'($urandom);
        end
        if (noise) bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_cmd(input int k, input bit noise);
        int t0, dn;
        issue(k, t0, dn);
        finish(dn, noise);
    endtask

    task automatic no_stall();
        for (int r = 0; r < DIM; r++) stall[r] = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rd_en"}, bus.a_rd_en | bus.b_rd_en, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_pe_clear"}, bus.pe_clear, 0);
        chk({tag, "_skew"}, bus.skew_valid, 0);
        chk({tag, "_c_wr_en"}, bus.c_wr_en, 0);
        chk({tag, "_c_wr_row"}, bus.c_wr_row, 0);
    endtask

    task automatic forget_pending();
        clr_q.delete();
        done_q.delete();
        rd_q.delete();
        wr_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0, dn;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.k_len = '0;
        bus.c_wr_ready = 1'b1;
`ifdef GEMM_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        no_stall();
        run_cmd(8, 1'b0);
        stall[2] = 3;
        run_cmd(8, 1'b0);
        no_stall();
        run_cmd(0, 1'b0);
        run_cmd(5, 1'b1);

        // Asynchronous reset while rd_addr==5.
        issue(8, t0, dn);
        while (cyc < t0 + 7) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("rd_addr_before_reset", bus.rd_addr, 5);
        #1;
        rst = 1'b1;
        forget_pending();
        busy_hi = -1;
        wr_hi   = -1;
        feed_k  = 0;
        #1;
        chk_idle_outputs("async_reset");
        #4;
        rst = 1'b0;
        run_cmd(8, 1'b0);

`ifdef GEMM_SEQ_ABORT_EN
        begin
            int ta;
            issue(2, t0, dn);
            ta = t0 + 2 + 2 + DC + 1;
            while (cyc < ta) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            abort = 1'b1;
            #6;
            forget_pending();
            busy_hi = ta;
            wr_hi   = ta;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("aborted_pulse", aborted, 1);
            chk("abort_busy", bus.busy, 0);
            chk("abort_c_wr_en", bus.c_wr_en, 0);
            @(posedge clk); #1;
            chk("aborted_clear", aborted, 0);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_idle_no_effect", aborted, 0);
        end
`endif

        for (int n = 0; n < 30; n++) begin
            for (int r = 0; r < DIM; r++)
                stall[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_cmd(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
        end

        repeat (DIM + DC) @(posedge clk);
        #1;
        chk("pending_clear", clr_q.size(), 0);
        chk("pending_rd", rd_q.size(), 0);
        chk("pending_wr", wr_q.size(), 0);
        chk("pending_done", done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Control FSM that runs one output tile on the DIM x DIM systolic GEMM array. It clears the PE accumulators and streams K operand slices from the A/B operand buffers into the array. It generates the per-row skewed valid strobes that match the array's register-chain skew, waits for the array to drain, then writes the DIM result rows back under a ready handshake. It sits between the host/CSR command interface and the datapath.

Parameters:
DIM, 4, systolic array rows/cols (>=2)
K_W, 16, width of the K-length command field
ADDR_W, 10, operand buffer address width
RD_LAT, 1, operand buffer read latency in cycles (>=1)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
k_len  in  K_W  number of K slices, latched on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
a_rd_en  out  1  A buffer read enable
b_rd_en  out  1  B buffer read enable
rd_addr  out  ADDR_W  shared A/B read address (slice index)
pe_clear  out  1  accumulator clear for all PEs
skew_valid  out  DIM  row i operand-valid, skewed by i cycles
c_wr_en  out  1  result row write request
c_wr_row  out  $clog2(DIM)  row being written
c_wr_ready  in  1  result sink accepts the row when high with c_wr_en

Behaviour:
- Reset (async, any state): state=IDLE, counters=0, skew chain=0; all outputs 0.
- FSM states and outputs are Moore (decoded from registered state/counters):
  - IDLE: start=1 latches k_len and moves to CLEAR.
  - CLEAR: pe_clear=1 for exactly 1 cycle. Moves to FEED, or to DRAIN if latched k_len==0.
  - FEED: a_rd_en=b_rd_en=1 for k_len cycles. rd_addr=0..k_len-1 increments each cycle; rd_addr takes the low ADDR_W bits of the counter (truncates if k_len > 2^ADDR_W). On the last slice, moves to DRAIN.
  - DRAIN: runs DRAIN_CYC = RD_LAT + 2*(DIM-1) + 1 cycles, then moves to WRITE.
  - WRITE: c_wr_en=1 with c_wr_row starting at 0. The row advances only on c_wr_en & c_wr_ready. c_wr_row is held stable while ready=0. Acceptance of row DIM-1 moves to DONE.
  - DONE: done=1 for 1 cycle, then moves to IDLE.
- start while busy is ignored (no queuing). start and the final DONE cycle coincident: ignored; the next start is needed in IDLE.
- Skew: feed_valid = (state==FEED), delayed RD_LAT cycles to give v0. skew_valid[i] = v0 delayed i further cycles. All stages reset to 0.
- k_len==0: no reads, all skew_valid stay 0, and the full DRAIN and WRITE still occur (C = cleared zeros).
- Cycle budget with ready always high: 1 + k_len + DRAIN_CYC + DIM + 1 cycles from start acceptance to done.

Optional Feature:
GEMM_SEQ_ABORT_EN:
- Defined: adds input abort (1 bit) and output aborted (1 bit).
  - abort=1 in any non-IDLE state forces IDLE on the next edge.
  - aborted pulses for that 1 cycle; done is not asserted.
  - The skew chain is flushed to 0 synchronously.
  - abort in IDLE has no effect.
- Undefined: ports absent; behaviour as above.

Decomposition:
- Package gemm_seq_pkg holds:
  - the state enum typedef (IDLE, CLEAR, FEED, DRAIN, WRITE, DONE)
  - the DRAIN_CYC computation as a function of DIM and RD_LAT
  - the row-index width helper
- One sub-module, skew_valid_line: a parameterised 1-bit delay chain (depth RD_LAT+DIM-1) with async active-high reset, exposing taps RD_LAT..RD_LAT+DIM-1 as skew_valid.

Test Plan:
- Nominal, DIM=4, RD_LAT=1, k_len=8, ready=1: start at cycle 0.
  - pe_clear at cycle 1; rd_addr 0..7 on cycles 2..9.
  - skew_valid[0] high cycles 3..10, skew_valid[3] high cycles 6..13.
  - DRAIN cycles 10..17; c_wr_row 0..3 on cycles 18..21; done at cycle 22.
- Backpressure: c_wr_ready low for 3 cycles on row 2 → c_wr_row holds at 2 with c_wr_en=1 and done slips by exactly 3 cycles.
- k_len=0: no rd_en and skew_valid all 0; 4 row writes occur; done at cycle 1+0+8+4+1=14.
- Start ignored: start pulsed during FEED and DRAIN → no effect; exactly one done; a second start at the DONE cycle is also ignored.
- Async reset mid-FEED (rd_addr=5): all outputs 0 immediately, skew_valid cleared, busy=0. A fresh start then runs the full sequence from rd_addr=0.
- With GEMM_SEQ_ABORT_EN: abort during WRITE row 1 → aborted pulse, IDLE next cycle, no done, c_wr_en=0.
